ins_fetch: RTL and testbench
============================

// Module: ins_fetch
// PURPOSE
//   Instruction fetch / prefetch unit: the producer of the 32-bit `ins` word that the control decoder consumes.
//   Sequences the PC, issues word reads to instruction memory and buffers returned words in a small FIFO.
//   Presents the FIFO head to decode with a valid/ready handshake.
//   Accepts PC redirects (jump/branch) from execute and flushes stale words.
// PARAMETERS
//   DEPTH     4             prefetch FIFO entries (power of 2, >=2)
//   RESET_PC  32'h0000_3000 first fetch address after reset
// PORTS
//   clk          in   1   single clock, all state on rising edge
//   rst_n        in   1   asynchronous, active-low reset
//   imem_req     out  1   read request to instruction memory
//   imem_addr    out  32  word address of request, [1:0]==2'b00
//   imem_ack     in   1   memory returns data this cycle
//   imem_rdata   in   32  instruction word, valid when imem_ack
//   redirect     in   1   execute requests PC change (1-cycle pulse)
//   redirect_pc  in   32  new fetch PC; bits [1:0] ignored (forced 00)
//   ins_valid    out  1   FIFO head valid
//   ins          out  32  FIFO head instruction, feeds the decoder `ins` input
//   ins_pc       out  32  PC of FIFO head (for PC_INC / branch calc)
//   ins_ready    in   1   decode accepts head this cycle
// BEHAVIOUR
//   Reset values: imem_req=0, imem_addr=RESET_PC, ins_valid=0, ins=0, ins_pc=0, FIFO count=0, state=IDLE.
//   Memory protocol: once imem_req rises, req and addr hold stable until the cycle imem_ack=1.
//     One request outstanding max; ack may come 1..N cycles after req (ack in same cycle as req rise allowed).
//   FSM states:
//     IDLE    imem_req=0; -> REQ when count<DEPTH
//     REQ     imem_req=1; on ack: push {addr,rdata}, addr+=4; stay REQ if count_after<DEPTH else -> IDLE
//     DISCARD imem_req=1 (old addr held); on ack: drop rdata, addr=saved redirect pc, -> REQ
//   Redirect (highest priority, same cycle):
//     FIFO flushed (count=0); ins_valid=0 next cycle.
//     REQ without ack   -> DISCARD, redirect_pc saved.
//     REQ with ack      -> rdata dropped, addr=redirect_pc, -> REQ.
//     IDLE              -> addr=redirect_pc, -> REQ.
//     DISCARD           -> saved pc overwritten by the newest redirect_pc.
//   Redirect with ins_valid&ins_ready in the same cycle: handshake counts as consumed, head still flushed.
//   Output: ins_valid=(count!=0), ins/ins_pc=head, registered; no combinational path ready->req.
//   Push and pop in the same cycle: count unchanged; push into a full FIFO is never possible by construction.
//   Address arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
//   Fetch latency: redirect at cycle t -> imem_req with new addr at t+1 (if no discard); data on ins at ack+1.
//   Reset mid-request: all state cleared asynchronously; an in-flight ack after reset is ignored (state IDLE).
// STRUCTURE
//   defines.vh: `FETCH_ST_IDLE/`FETCH_ST_REQ/`FETCH_ST_DISCARD (2-bit encodings), `FETCH_RESET_PC, `INS_WIDTH.
//   Sub-module fetch_fifo (DEPTH x 64b {pc,ins}, push/pop/flush, count, full/empty); FSM + PC regs in ins_fetch.
// TESTING
//   Reset release, memory acks every cycle, ready=1 -> addrs 3000,3004,3008..; ins_pc matches; 1 word/cycle after fill.
//   ins_ready=0 for 10 cycles -> exactly DEPTH(4) words buffered, imem_req drops; ready=1 -> resumes at 3010.
//   Redirect to 32'h0000_4002 while req waiting ack (3-cycle latency) -> old word dropped, next req addr 4000,
//     first ins_pc=4000.
//   Redirect coincident with imem_ack -> acked word never appears; next req addr = redirect_pc in next cycle.
//   Two redirects (5000 then 6000) during DISCARD -> fetch resumes at 6000 only.
//   PC at FFFF_FFF8 -> fetches FFFF_FFFC then 0000_0000; assert rst_n=0 mid-wait -> imem_req=0, ins_valid=0 at once.

Source files
------------

// File: rtl/ins_fetch_pkg.sv
// Shared types and constants for the instruction fetch / prefetch unit.
package ins_fetch_pkg;

  localparam int unsigned INS_WIDTH      = 32;
  localparam int unsigned FETCH_DEPTH    = 4;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  // One prefetch buffer entry: the fetch address travels with its word.
  typedef struct packed {
    logic [31:0]          pc;
    logic [INS_WIDTH-1:0] ins;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Wraps modulo 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/ins_fetch_if.sv
// Bundle of the fetch unit's memory, redirect and decode-side signals.
interface ins_fetch_if;

  logic                                imem_req;
  logic [31:0]                         imem_addr;
  logic                                imem_ack;
  logic [ins_fetch_pkg::INS_WIDTH-1:0] imem_rdata;
  logic                                redirect;
  logic [31:0]                         redirect_pc;
  logic                                ins_valid;
  logic [ins_fetch_pkg::INS_WIDTH-1:0] ins;
  logic [31:0]                         ins_pc;
  logic                                ins_ready;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, ins_valid, ins, ins_pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, ins_ready
  );

  // Environment side: instruction memory, execute and decode.
  modport slave (
    input  imem_req, imem_addr, ins_valid, ins, ins_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, ins_ready
  );

endinterface

// File: rtl/ins_fetch_fifo.sv
// Prefetch buffer: DEPTH entries of {pc, ins}, with a flush that empties it in one cycle.
module ins_fetch_fifo
  import ins_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  // Storage, pointers and occupancy; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch / prefetch unit: sequences the PC, reads instruction memory one
// word at a time, buffers words with their PCs and presents the head to decode.
//
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   ST_IDLE    | no request; buffer full, waiting for decode to drain a slot
//   ST_REQ     | request at addr_q outstanding; ack pushes {addr, rdata}
//   ST_DISCARD | stale request still outstanding after a redirect; its ack is
//              | dropped and fetching restarts at the saved redirect PC
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input logic         clk,
  input logic         rst_n,
  ins_fetch_if.master bus
);

  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   saved_pc_q, saved_pc_d;
  logic          push, pop, flush;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] count, count_after;
  fetch_entry_t  push_entry, head;
  logic [31:0]   redirect_pc_al;

  assign redirect_pc_al = word_align(bus.redirect_pc);
  // A redirect in the same cycle still counts the handshake as consumed; the flush
  // then clears whatever is left.
  assign pop            = ~fifo_empty & bus.ins_ready;
  assign count_after    = count + CW'(1) - CW'(pop);
  assign push_entry     = '{pc: addr_q, ins: bus.imem_rdata};

  ins_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (head),
    .count_o     (count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // State, fetch address and pending redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= RESET_PC;
      saved_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      saved_pc_q <= saved_pc_d;
    end
  end

  // Next-state and buffer control; redirect takes priority over everything else.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    saved_pc_d = saved_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.redirect) begin
          flush   = 1'b1;
          addr_d  = redirect_pc_al;
          state_d = ST_REQ;
        end else if (!fifo_full) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.redirect) begin
          flush = 1'b1;
          if (bus.imem_ack) begin
            addr_d  = redirect_pc_al;
          end else begin
            saved_pc_d = redirect_pc_al;
            state_d    = ST_DISCARD;
          end
        end else if (bus.imem_ack) begin
          push   = 1'b1;
          addr_d = pc_next(addr_q);
          if (count_after == DEPTH_C) state_d = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (bus.redirect) begin
          flush      = 1'b1;
          saved_pc_d = redirect_pc_al;
        end
        if (bus.imem_ack) begin
          addr_d  = bus.redirect ? redirect_pc_al : saved_pc_q;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.imem_req  = (state_q != ST_IDLE);
  assign bus.imem_addr = addr_q;
  assign bus.ins_valid = ~fifo_empty;
  assign bus.ins       = head.ins;
  assign bus.ins_pc    = head.pc;

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: memory responder with variable ack latency, decode with
// variable ready, and a reference model of the delivered instruction stream.
module tb_ins_fetch;
  import ins_fetch_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ins_fetch_if bus();

  ins_fetch #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        o_req, o_valid;
  logic [31:0] o_addr, o_ins, o_pc;
  logic        ack, ready;
  bit          hold_pending, new_req, exp_flush, redir_next;
  logic [31:0] hold_addr, redir_pc_next, exp_pc;
  int          wait_left, lat_mode, rdy_mode, n_consumed, n_acks;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic sample();
    o_req   = bus.imem_req;
    o_addr  = bus.imem_addr;
    o_valid = bus.ins_valid;
    o_ins   = bus.ins;
    o_pc    = bus.ins_pc;
  endtask

  task automatic clear_model();
    hold_pending = 1'b0;
    exp_flush    = 1'b0;
    redir_next   = 1'b0;
    wait_left    = 0;
    exp_pc       = RST_PC;
  endtask

  // One clock: observe outputs, answer memory/decode, apply any queued redirect, update the model.
  task automatic cycle();
    @(negedge clk);
    sample();
    if (exp_flush) check_eq("flush_valid", 32'(o_valid), 32'd0);
    if (hold_pending) begin
      check_eq("req_hold", 32'(o_req), 32'd1);
      check_eq("addr_hold", o_addr, hold_addr);
    end
    new_req = 1'b0;
    ack     = 1'b0;
    if (o_req) begin
      if (!hold_pending) begin
        new_req   = 1'b1;
        wait_left = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end
      if (wait_left == 0) ack = 1'b1;
      else wait_left--;
    end
    if (ack) n_acks++;
    hold_pending = o_req && !ack;
    hold_addr    = o_addr;
    ready = (rdy_mode == 2) ? ($urandom_range(0, 1) == 1) : (rdy_mode == 1);
    bus.imem_ack    = ack;
    bus.imem_rdata  = ack ? memf(o_addr) : $urandom;
    bus.ins_ready   = ready;
    bus.redirect    = redir_next;
    bus.redirect_pc = redir_pc_next;
    if (o_valid && ready) begin
      check_eq("ins_pc", o_pc, exp_pc);
      check_eq("ins", o_ins, memf(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_consumed++;
    end
    exp_flush = redir_next;
    if (redir_next) exp_pc = redir_pc_next & 32'hFFFF_FFFC;
    redir_next = 1'b0;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.ins_ready   = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    sample();
    check_eq("rst_req", 32'(o_req), 32'd0);
    check_eq("rst_addr", o_addr, RST_PC);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_ins", o_ins, 32'd0);
    check_eq("rst_pc", o_pc, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic find_fresh_req(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (new_req && !ack) found = 1'b1;
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_new_addr(input string tag, input logic [31:0] old, input logic [31:0] exp);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 15 && !found; i++) begin
      cycle();
      if (o_req && o_addr != old) begin
        check_eq(tag, o_addr, exp);
        found = 1'b1;
      end
    end
    check_eq({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  task automatic wait_first_valid(input string tag, input logic [31:0] exp);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (o_valid) begin
        check_eq(tag, o_pc, exp);
        found = 1'b1;
      end
    end
    check_eq({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    logic [31:0] old;
    lat_mode   = 0;
    rdy_mode   = 1;
    n_consumed = 0;
    n_acks     = 0;
    redir_pc_next = '0;

    // Streaming: ack every cycle, ready always.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle();
      check_eq("seq_addr", o_addr, RST_PC + 32'(4 * i));
      if (i >= 1) check_eq("stream_valid", 32'(o_valid), 32'd1);
    end

    // Decode stalls: exactly DEPTH words fetched, then request drops.
    do_reset();
    rdy_mode = 0;
    n_acks   = 0;
    repeat (10) cycle();
    check_eq("stall_acks", 32'(n_acks), 32'(DEPTH));
    check_eq("stall_req_low", 32'(o_req), 32'd0);
    check_eq("stall_valid", 32'(o_valid), 32'd1);
    check_eq("stall_head", o_pc, RST_PC);
    rdy_mode = 1;
    wait_new_addr("resume_addr", RST_PC + 32'hC, 32'h0000_3010);

    // Redirect while a request waits for its ack.
    lat_mode = 3;
    find_fresh_req("fresh_req_a");
    old = o_addr;
    redir_next = 1'b1; redir_pc_next = 32'h0000_4002;
    cycle();
    check_eq("redir_wait_noack", 32'(ack), 32'd0);
    wait_new_addr("redir_addr", old, 32'h0000_4000);
    wait_first_valid("redir_first_pc", 32'h0000_4000);

    // Redirect in the same cycle as an ack.
    lat_mode = 0;
    repeat (6) cycle();
    redir_next = 1'b1; redir_pc_next = 32'h0000_7000;
    cycle();
    check_eq("coinc_ack", 32'(ack), 32'd1);
    cycle();
    check_eq("coinc_addr", o_addr, 32'h0000_7000);
    wait_first_valid("coinc_first_pc", 32'h0000_7000);

    // Two redirects while discarding: only the newest target survives.
    lat_mode = 3;
    find_fresh_req("fresh_req_b");
    old = o_addr;
    redir_next = 1'b1; redir_pc_next = 32'h0000_5000;
    cycle();
    redir_next = 1'b1; redir_pc_next = 32'h0000_6000;
    cycle();
    check_eq("dbl_noack", 32'(ack), 32'd0);
    wait_new_addr("dbl_addr", old, 32'h0000_6000);
    wait_first_valid("dbl_first_pc", 32'h0000_6000);

    // Address wrap past the top of the address space.
    lat_mode = 0;
    repeat (6) cycle();
    redir_next = 1'b1; redir_pc_next = 32'hFFFF_FFF8;
    cycle();
    cycle();
    check_eq("wrap_a0", o_addr, 32'hFFFF_FFF8);
    cycle();
    check_eq("wrap_a1", o_addr, 32'hFFFF_FFFC);
    cycle();
    check_eq("wrap_a2", o_addr, 32'h0000_0000);
    repeat (4) cycle();

    // Reset asserted while a request is outstanding; a late ack must be ignored.
    lat_mode = 3;
    find_fresh_req("fresh_req_c");
    #2 rst_n = 1'b0;
    #1 sample();
    check_eq("midrst_req", 32'(o_req), 32'd0);
    check_eq("midrst_valid", 32'(o_valid), 32'd0);
    check_eq("midrst_addr", o_addr, RST_PC);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    bus.redirect   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sample();
    check_eq("postrst_valid", 32'(o_valid), 32'd0);
    check_eq("postrst_req", 32'(o_req), 32'd1);
    check_eq("postrst_addr", o_addr, RST_PC);
    bus.imem_ack = 1'b0;
    clear_model();
    wait_first_valid("postrst_first_pc", RST_PC);

    // Random traffic against the stream model.
    lat_mode   = -1;
    rdy_mode   = 2;
    n_consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        redir_next    = 1'b1;
        redir_pc_next = $urandom;
      end
      cycle();
    end
    check_eq("progress", 32'(n_consumed > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
